// File: rtl/div_ratio_sched_pkg.sv
// Shared types and helpers for the divided-clock ratio scheduler.
package div_ratio_sched_pkg;

  localparam int unsigned DEFAULT_STAGES = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PEND
  } state_t;

  // Select values past the last stage map onto the slowest available ratio.
  function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned stages);
    return (sel >= stages) ? stages - 1 : sel;
  endfunction

endpackage

// File: rtl/div_ratio_sched_stage_chain.sv
// Chain of divide-by-2 stages as an enabled binary counter; bit k is stage k.
module div_stage_chain
  import div_ratio_sched_pkg::*;
#(
  parameter int unsigned STAGES = DEFAULT_STAGES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  output logic [STAGES-1:0] cnt,
  output logic [STAGES-1:0] cnt_next
);

  assign cnt_next = cnt + STAGES'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/div_ratio_sched.sv
// Ratio scheduler: picks which stage drives div_out and swaps ratios only on
// period boundaries so the divided output never glitches.
module div_ratio_sched
  import div_ratio_sched_pkg::*;
#(
  parameter int unsigned STAGES = DEFAULT_STAGES,
  parameter int unsigned SEL_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              sel_req_valid,
  input  logic [SEL_W-1:0]  sel_req,
  output logic              sel_req_ready,
  output logic [SEL_W-1:0]  sel_active,
  output logic [STAGES-1:0] cnt,
  output logic              div_out,
  output logic              tick,
  output logic              busy
);

  state_t            state;
  logic [SEL_W-1:0]  pending;
  logic [SEL_W-1:0]  req_clamped;
  logic [SEL_W-1:0]  new_sel;
  logic [STAGES-1:0] cnt_next;
  logic [STAGES-1:0] sel_onehot;
  logic [STAGES-1:0] sel_mask;
  logic              accept;
  logic              boundary;
  logic              apply_pend;
  logic              apply_now;
  logic              clr;
  logic              stage_bit;

  assign sel_req_ready = (state != PEND);
  assign busy          = (state == PEND);

  always_comb begin
    sel_onehot = '0;
    sel_mask   = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      sel_onehot[k] = (32'(sel_active) == k);
      sel_mask[k]   = (k <= 32'(sel_active));
    end
    req_clamped = SEL_W'(clamp_sel(32'(sel_req), STAGES));
    accept      = sel_req_valid & sel_req_ready;
    boundary    = en & ((cnt_next & sel_mask) == '0);
    stage_bit   = |(cnt_next & sel_onehot);
    // A latched change lands at a boundary, or immediately when the run stops;
    // requests arriving while stopped bypass the pending stage entirely.
    apply_pend  = (state == PEND) & (~en | boundary);
    apply_now   = accept & (~en | (state == IDLE));
    clr         = apply_pend | apply_now;
    new_sel     = apply_pend ? pending : req_clamped;
  end

  div_stage_chain #(
    .STAGES(STAGES)
  ) u_chain (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .clr      (clr),
    .cnt      (cnt),
    .cnt_next (cnt_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sel_active <= '0;
      pending    <= '0;
      div_out    <= 1'b0;
      tick       <= 1'b0;
    end else begin
      if (clr) begin
        sel_active <= new_sel;
        div_out    <= 1'b0;
        tick       <= 1'b0;
      end else if (en) begin
        div_out <= stage_bit;
        tick    <= ~div_out & stage_bit;
      end else begin
        tick <= 1'b0;
      end

      if (accept && !apply_now) begin
        pending <= req_clamped;
      end

      case (state)
        IDLE: if (en) state <= RUN;
        RUN: begin
          if (!en)        state <= IDLE;
          else if (accept) state <= PEND;
        end
        PEND: begin
          if (!en)          state <= IDLE;
          else if (boundary) state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
